serial_rx: RTL and testbench

//  UART-style receiver: 8N1 frame (start bit low, 8 data bits LSB first, stop bit high), no parity.

---
 rtl/serial_rx.sv | 144 ++++++++++++++
 tb/tb_serial_rx.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/serial_rx.sv
// 8N1 UART receiver. The rx pin passes through a two-flop synchronizer, then each bit
// is sampled at its midpoint. Good bytes raise new_data; a low stop bit raises frame_err.
module serial_rx #(
    parameter int unsigned CLK_PER_BIT = 16,
    parameter int unsigned CTR_SIZE    = $clog2(CLK_PER_BIT)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       new_data,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned HALF = CLK_PER_BIT / 2;
    localparam logic [CTR_SIZE-1:0] HALF_M1 = CTR_SIZE'(HALF - 1);
    localparam logic [CTR_SIZE-1:0] LAST    = CTR_SIZE'(CLK_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStartBit,
        StData,
        StStopBit,
        StWaitHigh
    } state_e;

    state_e              state_q, state_d;
    logic [CTR_SIZE-1:0] ctr_q, ctr_d;
    logic [2:0]          bit_ctr_q, bit_ctr_d;
    logic [7:0]          shift_q, shift_d;
    logic [7:0]          data_q, data_d;
    logic                new_data_q, new_data_d;
    logic                frame_err_q, frame_err_d;
    logic                rx_meta_q, rx_s_q;

    // Synchronizer resets to the idle-high level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ctr_q       <= '0;
            bit_ctr_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            new_data_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            bit_ctr_q   <= bit_ctr_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            new_data_q  <= new_data_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ctr_d       = ctr_q;
        bit_ctr_d   = bit_ctr_q;
        shift_d     = shift_q;
        data_d      = data_q;
        new_data_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            StIdle: begin
                ctr_d     = '0;
                bit_ctr_d = '0;
                if (!rx_s_q) begin
                    state_d = StStartBit;
                end
            end

            StStartBit: begin
                ctr_d = ctr_q + 1'b1;
                if (ctr_q == HALF_M1) begin
                    if (!rx_s_q) begin
                        ctr_d   = '0;
                        state_d = StData;
                    end else begin
                        // Line went high again before mid-bit: noise, not a frame.
                        state_d = StIdle;
                    end
                end
            end

            StData: begin
                ctr_d = ctr_q + 1'b1;
                if (ctr_q == LAST) begin
                    shift_d[bit_ctr_q] = rx_s_q;
                    ctr_d              = '0;
                    bit_ctr_d          = bit_ctr_q + 3'd1;
                    if (bit_ctr_q == 3'd7) begin
                        state_d = StStopBit;
                    end
                end
            end

            StStopBit: begin
                ctr_d = ctr_q + 1'b1;
                if (ctr_q == LAST) begin
                    ctr_d = '0;
                    if (rx_s_q) begin
                        data_d     = shift_q;
                        new_data_d = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StWaitHigh;
                    end
                end
            end

            StWaitHigh: begin
                ctr_d = '0;
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign data      = data_q;
    assign new_data  = new_data_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx: bit-banged 8N1 frames, pulse monitor and immediate-assertion checks.
module tb_serial_rx;

    localparam int unsigned CPB = 16;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       new_data;
    logic       frame_err;
    logic       busy;

    int vectors;
    int miscompares;
    int cyc;
    int start_cyc;
    int nd_count;
    int nd_cyc;
    int fe_count;
    int both_count;
    logic [7:0] got [0:7];

    serial_rx #(
        .CLK_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .data     (data),
        .new_data (new_data),
        .frame_err(frame_err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Pulse monitor, sampled on the falling edge away from the active edge.
    always @(negedge clk) begin
        if (new_data) begin
            if (nd_count < 8) got[nd_count] = data;
            nd_count++;
            nd_cyc = cyc;
        end
        if (frame_err) fe_count++;
        if (new_data && frame_err) both_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        nd_count = 0;
        fe_count = 0;
        for (int i = 0; i < 8; i++) got[i] = 8'hxx;
    endtask

    task automatic bit_time(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        start_cyc = cyc;
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(stop);
        rx = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        nd_cyc      = 0;
        both_count  = 0;
        clear_mon();
        rx  = 1'b1;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("reset_data", 32'(data), 32'h00);
        check("reset_new_data", 32'(new_data), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);

        // 1: single frame 0x55, latency 155 +/- 1 cycles
        clear_mon();
        send_byte(8'h55, 1'b1);
        idle(20);
        check("t1_pulses", 32'(nd_count), 32'd1);
        check("t1_data", 32'(data), 32'h55);
        check("t1_latency_ok", 32'((nd_cyc - start_cyc >= 154) && (nd_cyc - start_cyc <= 156)), 32'd1);
        check("t1_frame_err", 32'(fe_count), 32'd0);

        // 2: back-to-back frames with zero idle time
        clear_mon();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        idle(40);
        check("t2_pulses", 32'(nd_count), 32'd3);
        check("t2_byte0", 32'(got[0]), 32'hA5);
        check("t2_byte1", 32'(got[1]), 32'h00);
        check("t2_byte2", 32'(got[2]), 32'hFF);
        check("t2_frame_err", 32'(fe_count), 32'd0);

        // 3: 5-cycle glitch rejected at start-bit midpoint
        clear_mon();
        rx = 1'b0;
        repeat (5) @(negedge clk);
        check("t3_busy_during", 32'(busy), 32'd1);
        idle(20);
        check("t3_busy_after", 32'(busy), 32'd0);
        check("t3_pulses", 32'(nd_count), 32'd0);
        check("t3_frame_err", 32'(fe_count), 32'd0);

        // 4: bad stop bit, then a good frame
        clear_mon();
        send_byte(8'h3C, 1'b0);
        idle(40);
        check("t4_frame_err", 32'(fe_count), 32'd1);
        check("t4_no_pulse", 32'(nd_count), 32'd0);
        check("t4_data_kept", 32'(data), 32'hFF);
        check("t4_busy_idle", 32'(busy), 32'd0);
        send_byte(8'h81, 1'b1);
        idle(20);
        check("t4_next_pulses", 32'(nd_count), 32'd1);
        check("t4_next_data", 32'(data), 32'h81);
        check("t4_fe_total", 32'(fe_count), 32'd1);

        // 5: line stuck low for 40 bit times
        clear_mon();
        rx = 1'b0;
        repeat (40 * CPB) @(negedge clk);
        check("t5_frame_err", 32'(fe_count), 32'd1);
        check("t5_no_pulse", 32'(nd_count), 32'd0);
        check("t5_wait_high_busy", 32'(busy), 32'd1);
        idle(20);
        check("t5_busy_after", 32'(busy), 32'd0);
        check("t5_fe_total", 32'(fe_count), 32'd1);
        check("t5_data_kept", 32'(data), 32'h81);

        // 6: reset pulse during bit 4 of 0x7E, then a full 0x7E
        clear_mon();
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) bit_time(1'(8'h7E >> i));
        rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_busy_after_rst", 32'(busy), 32'd0);
        check("t6_data_cleared", 32'(data), 32'h00);
        idle(3 * CPB);
        check("t6_no_pulse", 32'(nd_count), 32'd0);
        send_byte(8'h7E, 1'b1);
        idle(20);
        check("t6_pulses", 32'(nd_count), 32'd1);
        check("t6_data", 32'(data), 32'h7E);
        check("t6_frame_err", 32'(fe_count), 32'd0);

        check("pulses_exclusive", 32'(both_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
